// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Contents: receiver FSM state type, data width, baud divider helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  // Core clock cycles per bit (integer division, truncating).
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with a registered head entry and registered valid.
// Ports:
//   core_clk, core_rst_n : clock, async active-low reset
//   i_push, i_wdata      : write request and data (dropped when full and not popping)
//   i_pop                : read request (ignored when empty)
//   o_full_c             : combinational full indication
//   o_head               : registered head entry
//   o_valid              : registered not-empty
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full_c,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_wr_n;
  logic [PW-1:0] w_rd_n;
  logic [AW-1:0] w_rd_nxt_idx;

  assign w_full       = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_empty      = (r_wr == r_rd);
  assign w_pop        = i_pop && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push       = i_push && (!w_full || w_pop);
  assign w_count      = r_wr - r_rd;
  assign w_wr_n       = r_wr + PW'(w_push);
  assign w_rd_n       = r_rd + PW'(w_pop);
  assign w_rd_nxt_idx = r_rd[AW-1:0] + AW'(1);
  assign o_full_c     = w_full;

  // Storage and pointers.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
      r_wr <= w_wr_n;
      r_rd <= w_rd_n;
    end
  end

  // Head register tracks the entry that will sit at the read pointer next cycle.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      o_head  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (w_push && (w_empty || (w_pop && w_count == PW'(1)))) begin
        o_head <= i_wdata;
      end else if (w_pop && w_count != PW'(1)) begin
        o_head <= r_mem[w_rd_nxt_idx];
      end
      o_valid <= (w_wr_n != w_rd_n);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, receive FIFO, sticky error flags.
// Ports:
//   core_clk, core_rst_n     : clock, async active-low reset
//   ser_rx_i                 : asynchronous serial line, idle high
//   rx_data_o, rx_valid_o    : FIFO head byte and not-empty
//   rx_ready_i               : consumer pop
//   frame_err_o, overrun_o   : sticky error flags
//   clr_err_i                : clears both sticky flags (a simultaneous set wins)
//   busy_o                   : receiver is not idle
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      core_clk,
  input  logic                      core_rst_n,
  input  logic                      ser_rx_i,
  output logic [UART_DATA_BITS-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  input  logic                      clr_err_i,
  output logic                      busy_o
);

  localparam int unsigned DIV  = baud_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam int unsigned IW   = $clog2(UART_DATA_BITS);

  uart_rx_state_e            r_state;
  logic                      r_sync1;
  logic                      r_sync2;
  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;

  logic w_rx_s;
  logic w_cnt_done;
  logic w_cnt_half;
  logic w_stop_smp;
  logic w_push;
  logic w_ferr;
  logic w_ovr;
  logic w_fifo_full;

  assign w_rx_s     = r_sync2;
  assign w_cnt_done = (r_cnt == CW'(DIV - 1));
  assign w_cnt_half = (r_cnt == CW'(HALF - 1));
  assign w_stop_smp = (r_state == STOP) && w_cnt_done;
  assign w_push     = w_stop_smp && w_rx_s;
  assign w_ferr     = w_stop_smp && !w_rx_s;
  assign w_ovr      = w_push && w_fifo_full && !rx_ready_i;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ser_rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Deframing FSM with baud counter and shift register; busy follows the next state.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
            busy_o  <= 1'b1;
          end
        end
        START: begin
          if (w_cnt_half) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              // Line back high at mid start bit: treat as a glitch.
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_cnt_done) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == IW'(UART_DATA_BITS - 1)) r_state <= STOP;
            else                                  r_idx   <= r_idx + IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_cnt_done) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              r_state <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line returns high so a break is not taken as a start bit.
          if (w_rx_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (w_ferr)         frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;
      if (w_ovr)          overrun_o   <= 1'b1;
      else if (clr_err_i) overrun_o   <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .i_push     (w_push),
    .i_wdata    (r_shift),
    .i_pop      (rx_ready_i),
    .o_full_c   (w_fifo_full),
    .o_head     (rx_data_o),
    .o_valid    (rx_valid_o)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives serial frames and checks received bytes and flags
// against an expected-byte queue built from what was sent.
module tb_uart_rx_core;

  localparam int BIT   = 25_000_000 / 115200;  // 217 cycles per bit
  localparam int HALFB = BIT / 2;              // 108
  localparam int DEPTH = 4;

  logic       core_clk   = 1'b0;
  logic       core_rst_n = 1'b0;
  logic       ser_rx_i   = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic       clr_err_i  = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx_core dut (
    .core_clk    (core_clk),
    .core_rst_n  (core_rst_n),
    .ser_rx_i    (ser_rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clr_err_i   (clr_err_i),
    .busy_o      (busy_o)
  );

  always #20 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  // Monitor: collect consumed bytes, valid pulse lengths and rise times.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   run       = 0;
  int   last_run  = 0;
  int   rise_cyc  = 0;
  logic prev_vld  = 1'b0;

  always @(negedge core_clk) begin
    if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
    if (rx_valid_o && !prev_vld) rise_cyc = cyc;
    if (rx_valid_o) run = run + 1;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    prev_vld = rx_valid_o;
  end

  int total    = 0;
  int bad      = 0;
  int chk_from = 0;
  int t0       = 0;
  int lat      = 0;
  int bc       = 0;
  logic [7:0] rb;
  logic [7:0] partial;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk_from = exp_q.size();
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  // One 8N1 frame, LSB first; line left at the stop level.
  task automatic send_byte(input logic [7:0] b, input int bit_cyc, input logic stop_v);
    ser_rx_i = 1'b0;
    tick(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      ser_rx_i = b[i];
      tick(bit_cyc);
    end
    ser_rx_i = stop_v;
    tick(bit_cyc);
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_valid", 32'(rx_valid_o), 32'd0);
    check("rst_data", 32'(rx_data_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    core_rst_n = 1'b1;
    tick(5);

    // Single byte with consumer always ready: one-cycle valid pulse near 9.5 bits
    rx_ready_i = 1'b1;
    t0 = cyc;
    send_byte(8'h68, BIT, 1'b1);
    exp_q.push_back(8'h68);
    tick(20);
    check_stream("t1");
    check("t1_pulse_len", 32'(last_run), 32'd1);
    // 2 sync cycles + 1 detect + HALF to mid start + 9 bits to mid stop, +/-2 tolerance
    lat = rise_cyc - t0;
    check("t1_latency_ok", 32'(lat >= (3 + HALFB + 9*BIT - 2) && lat <= (3 + HALFB + 9*BIT + 2)), 32'd1);
    check("t1_ferr", 32'(frame_err_o), 32'd0);
    check("t1_ovr", 32'(overrun_o), 32'd0);

    // Short low glitch is rejected at the mid start-bit sample
    ser_rx_i = 1'b0;
    tick(50);
    check("t2_busy_in_start", 32'(busy_o), 32'd1);
    ser_rx_i = 1'b1;
    tick(2*BIT);
    check("t2_busy_after", 32'(busy_o), 32'd0);
    check_stream("t2");
    check("t2_ferr", 32'(frame_err_o), 32'd0);
    check("t2_ovr", 32'(overrun_o), 32'd0);

    // Framing error followed by a break, then a good byte
    send_byte(8'h55, BIT, 1'b0);
    tick(3*BIT);
    check("t3_ferr_set", 32'(frame_err_o), 32'd1);
    check("t3_busy_wait", 32'(busy_o), 32'd1);
    check("t3_no_valid", 32'(rx_valid_o), 32'd0);
    ser_rx_i = 1'b1;
    tick(20);
    check("t3_busy_idle", 32'(busy_o), 32'd0);
    send_byte(8'hA5, BIT, 1'b1);
    exp_q.push_back(8'hA5);
    tick(20);
    check_stream("t3");
    check("t3_ferr_sticky", 32'(frame_err_o), 32'd1);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    check("t3_ferr_clr", 32'(frame_err_o), 32'd0);

    // Overrun: five bytes into a four-deep FIFO with no consumer
    rx_ready_i = 1'b0;
    tick(5);
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b), BIT, 1'b1);
      if (b <= DEPTH) exp_q.push_back(8'(b));
    end
    tick(20);
    check("t4_valid", 32'(rx_valid_o), 32'd1);
    check("t4_head", 32'(rx_data_o), 32'h01);
    check("t4_ovr", 32'(overrun_o), 32'd1);
    rx_ready_i = 1'b1;
    tick(10);
    rx_ready_i = 1'b0;
    check_stream("t4");
    check("t4_empty", 32'(rx_valid_o), 32'd0);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    check("t4_ovr_clr", 32'(overrun_o), 32'd0);

    // Reset in the middle of 0xC3 (during bit 4), then 0x3C
    rx_ready_i = 1'b1;
    partial = 8'hC3;
    ser_rx_i = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      ser_rx_i = partial[i];
      tick(BIT);
    end
    ser_rx_i = partial[4];
    tick(BIT/2);
    check("t5_busy_pre", 32'(busy_o), 32'd1);
    core_rst_n = 1'b0;
    ser_rx_i   = 1'b1;
    tick(3);
    check("t5_rst_valid", 32'(rx_valid_o), 32'd0);
    check("t5_rst_data", 32'(rx_data_o), 32'd0);
    check("t5_rst_busy", 32'(busy_o), 32'd0);
    check("t5_rst_ferr", 32'(frame_err_o), 32'd0);
    check("t5_rst_ovr", 32'(overrun_o), 32'd0);
    core_rst_n = 1'b1;
    tick(5);
    send_byte(8'h3C, BIT, 1'b1);
    exp_q.push_back(8'h3C);
    tick(20);
    check_stream("t5");

    // 16 random bytes back-to-back, each with up to +/-2% bit-time skew
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom);
      bc = int'($urandom_range(BIT + 4, BIT - 4));
      send_byte(rb, bc, 1'b1);
      exp_q.push_back(rb);
    end
    tick(20);
    check_stream("t6");
    check("t6_ferr", 32'(frame_err_o), 32'd0);
    check("t6_ovr", 32'(overrun_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
